// File: rtl/uart_rx_pkg.sv
// Shared types, sample points and frame-length helpers for the UART receive deframer.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic [3:0] SAMPLE_T0     = 4'd7;
  localparam logic [3:0] SAMPLE_T1     = 4'd8;
  localparam logic [3:0] SAMPLE_T2     = 4'd9;
  localparam int         TICKS_PER_BIT = 16;

  function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

  // Four character times of x16 ticks: frame_bits * 4 * 16.
  function automatic logic [9:0] timeout_thresh(input logic [1:0] wls, input logic pen);
    logic [9:0] frame_bits;
    frame_bits = 10'd7 + {8'd0, wls} + {9'd0, pen};
    return frame_bits << 6;
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Synchronises the raw rx line, flags falling edges and majority-votes
// the samples taken at ticks 7, 8 and 9 of each bit period.
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  input  logic       tick_i,
  input  logic [3:0] tick_cnt_i,
  output logic       rx_sync_o,
  output logic       fall_edge_o,
  output logic       bit_val_o,
  output logic       bit_val_strobe_o
);

  logic sync1_q, sync2_q, sync3_q;
  logic samp0_q, samp1_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
      samp0_q <= 1'b1;
      samp1_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (tick_i && tick_cnt_i == SAMPLE_T0) samp0_q <= sync2_q;
      if (tick_i && tick_cnt_i == SAMPLE_T1) samp1_q <= sync2_q;
    end
  end

  // Third vote is the live synchronised value on the tick-9 strobe.
  assign rx_sync_o        = sync2_q;
  assign fall_edge_o      = sync3_q & ~sync2_q;
  assign bit_val_o        = (samp0_q & samp1_q) | (samp0_q & sync2_q) | (samp1_q & sync2_q);
  assign bit_val_strobe_o = tick_i && (tick_cnt_i == SAMPLE_T2);

endmodule

// File: rtl/uart_rx_deframer.sv
// 16x-oversampled UART receive deframer feeding the RX FIFO write port.
// Optional idle-character timeout is built when UART_RX_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a synchronised falling edge
// START  | validating the start bit, false start returns to IDLE
// DATA   | shifting in 5..8 data bits, LSB first
// PARITY | capturing and checking the parity bit
// STOP   | sampling the stop bit, writing or dropping the character
module uart_rx_deframer
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_rx,
  input  logic                  i_tick16,
  input  logic [1:0]            i_wls,
  input  logic                  i_pen,
  input  logic                  i_eps,
  input  logic                  i_stick,
  input  logic                  i_fifo_full,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_wr,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break_det,
  output logic                  o_overrun,
`ifdef UART_RX_TIMEOUT_EN
  input  logic                  i_fifo_empty,
  input  logic                  i_fifo_rd,
  output logic                  o_timeout,
`endif
  output logic                  o_busy
);

  localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);

  rx_state_e             state_q, state_d;
  logic [3:0]            tick_cnt_q, tick_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  all_zero_q, all_zero_d;
  logic                  par_err_q, par_err_d;
  logic [1:0]            wls_q, wls_d;
  logic                  pen_q, pen_d, eps_q, eps_d, stick_q, stick_d;
  logic                  line_hold_q, line_hold_d;
  logic                  rx_wr_q, rx_wr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d, ovr_q, ovr_d;

  logic rx_sync, fall_edge, bit_val, bit_strobe;
  logic wrap, last_data_bit;

  uart_rx_bit_sampler u_sampler (
    .clk_i            (i_sys_clk),
    .rst_n_i          (i_sys_rst_n),
    .rx_i             (i_rx),
    .tick_i           (i_tick16),
    .tick_cnt_i       (tick_cnt_q),
    .rx_sync_o        (rx_sync),
    .fall_edge_o      (fall_edge),
    .bit_val_o        (bit_val),
    .bit_val_strobe_o (bit_strobe)
  );

  assign wrap          = i_tick16 && (tick_cnt_q == LAST_TICK);
  assign last_data_bit = (bit_cnt_q == 3'(wls_to_bits(wls_q) - 4'd1));

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    all_zero_d  = all_zero_q;
    par_err_d   = par_err_q;
    wls_d       = wls_q;
    pen_d       = pen_q;
    eps_d       = eps_q;
    stick_d     = stick_q;
    line_hold_d = line_hold_q;
    rx_wr_d     = 1'b0;
    rx_data_d   = rx_data_q;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    brk_d       = 1'b0;
    ovr_d       = 1'b0;

    if (rx_sync) line_hold_d = 1'b0;
    if (state_q != IDLE && i_tick16) tick_cnt_d = wrap ? 4'd0 : tick_cnt_q + 4'd1;

    case (state_q)
      IDLE: begin
        tick_cnt_d = 4'd0;
        if (fall_edge && !line_hold_q) begin
          state_d    = START;
          wls_d      = i_wls;
          pen_d      = i_pen;
          eps_d      = i_eps;
          stick_d    = i_stick;
          shift_d    = '0;
          bit_cnt_d  = 3'd0;
          all_zero_d = 1'b1;
          par_err_d  = 1'b0;
        end
      end
      START: begin
        if (bit_strobe && bit_val) begin
          state_d    = IDLE;
          tick_cnt_d = 4'd0;
        end else if (wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_strobe) begin
          shift_d[bit_cnt_q] = bit_val;
          if (bit_val) all_zero_d = 1'b0;
        end
        if (wrap) begin
          if (last_data_bit) state_d = pen_q ? PARITY : STOP;
          else               bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      PARITY: begin
        if (bit_strobe) begin
          if (bit_val) all_zero_d = 1'b0;
          par_err_d = stick_q ? (bit_val != ~eps_q)
                              : ((^shift_q ^ bit_val) != ~eps_q);
        end
        if (wrap) state_d = STOP;
      end
      STOP: begin
        // Leave at the decision point so a start edge right after the stop bit is seen.
        if (bit_strobe) begin
          state_d    = IDLE;
          tick_cnt_d = 4'd0;
          if (!bit_val) line_hold_d = 1'b1;
          if (i_fifo_full) begin
            ovr_d = 1'b1;
          end else begin
            rx_wr_d   = 1'b1;
            rx_data_d = shift_q;
            perr_d    = par_err_q;
            ferr_d    = ~bit_val;
            brk_d     = all_zero_q & ~bit_val;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q     <= IDLE;
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= '0;
      all_zero_q  <= 1'b0;
      par_err_q   <= 1'b0;
      wls_q       <= 2'd0;
      pen_q       <= 1'b0;
      eps_q       <= 1'b0;
      stick_q     <= 1'b0;
      line_hold_q <= 1'b0;
      rx_wr_q     <= 1'b0;
      rx_data_q   <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      all_zero_q  <= all_zero_d;
      par_err_q   <= par_err_d;
      wls_q       <= wls_d;
      pen_q       <= pen_d;
      eps_q       <= eps_d;
      stick_q     <= stick_d;
      line_hold_q <= line_hold_d;
      rx_wr_q     <= rx_wr_d;
      rx_data_q   <= rx_data_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      brk_q       <= brk_d;
      ovr_q       <= ovr_d;
    end
  end

  assign o_rx_data    = rx_data_q;
  assign o_rx_wr      = rx_wr_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_break_det  = brk_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = (state_q != IDLE);

`ifdef UART_RX_TIMEOUT_EN
  logic [9:0] to_cnt_q, to_cnt_d;
  logic       timeout_q, timeout_d;

  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if (rx_wr_q || i_fifo_rd || i_fifo_empty || state_q != IDLE) begin
      to_cnt_d  = 10'd0;
      timeout_d = 1'b0;
    end else if (i_tick16 && !timeout_q) begin
      to_cnt_d = to_cnt_q + 10'd1;
      if (to_cnt_d == timeout_thresh(i_wls, i_pen)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      to_cnt_q  <= 10'd0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: directed frames, monitor-side checking.
`timescale 1ns/1ps
module tb_uart_rx_deframer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] wls = 2'd3;
  logic       pen = 1'b0, eps = 1'b0, stick = 1'b0, full = 1'b0;
  logic [7:0] rx_data;
  logic       rx_wr, perr, ferr, brk, ovr, busy;
`ifdef UART_RX_TIMEOUT_EN
  logic       fifo_empty = 1'b1, fifo_rd = 1'b0, timeout;
  int         to_n;
`endif

  int tests = 0, fails = 0, wr_cnt = 0, ovr_cnt = 0;
  int div = 0;

  typedef struct {
    logic       ovr;
    logic [7:0] data;
    logic       perr, ferr, brk;
  } exp_t;
  exp_t exp_q[$];

  always #10 clk = ~clk;

  // x16 tick every fourth clock
  always @(posedge clk) begin
    div  <= (div == 3) ? 0 : div + 1;
    tick <= (div == 3);
  end

  uart_rx_deframer #(.DATA_WIDTH(8), .TICKS_PER_BIT(16)) dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .i_rx         (rx),
    .i_tick16     (tick),
    .i_wls        (wls),
    .i_pen        (pen),
    .i_eps        (eps),
    .i_stick      (stick),
    .i_fifo_full  (full),
    .o_rx_data    (rx_data),
    .o_rx_wr      (rx_wr),
    .o_parity_err (perr),
    .o_frame_err  (ferr),
    .o_break_det  (brk),
    .o_overrun    (ovr),
`ifdef UART_RX_TIMEOUT_EN
    .i_fifo_empty (fifo_empty),
    .i_fifo_rd    (fifo_rd),
    .o_timeout    (timeout),
`endif
    .o_busy       (busy)
  );

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (!rx_wr && (perr || ferr || brk)) begin
        tests++; fails++;
        $display("FAIL flags_without_wr perr=%0b ferr=%0b brk=%0b required 0", perr, ferr, brk);
      end
      if (rx_wr || ovr) begin
        if (rx_wr) wr_cnt++;
        if (ovr) ovr_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output wr=%0b ovr=%0b data=%h required no output", rx_wr, ovr, rx_data);
        end else begin
          e = exp_q.pop_front();
          if (e.ovr) begin
            if (!(ovr && !rx_wr)) begin
              fails++;
              $display("FAIL overrun_pulse wr=%0b ovr=%0b required wr=0 ovr=1", rx_wr, ovr);
            end
          end else if (!rx_wr || ovr || rx_data !== e.data || perr !== e.perr ||
                       ferr !== e.ferr || brk !== e.brk) begin
            fails++;
            $display("FAIL rx_char got wr=%0b ovr=%0b data=%h p=%0b f=%0b b=%0b required data=%h p=%0b f=%0b b=%0b",
                     rx_wr, ovr, rx_data, perr, ferr, brk, e.data, e.perr, e.ferr, e.brk);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (tick !== 1'b1);
    end
    #1;
  endtask

  task automatic expect_wr(input logic [7:0] d, input logic p, input logic f, input logic b);
    exp_t e;
    e.ovr = 1'b0; e.data = d; e.perr = p; e.ferr = f; e.brk = b;
    exp_q.push_back(e);
  endtask

  task automatic expect_ovr();
    exp_t e;
    e.ovr = 1'b1; e.data = 8'h00; e.perr = 1'b0; e.ferr = 1'b0; e.brk = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic send_char(input int nbits, input logic [7:0] d, input bit use_par,
                           input logic pbit, input logic stop_b, input bit scramble);
    logic [1:0] s_wls;
    logic       s_pen, s_eps;
    s_wls = wls; s_pen = pen; s_eps = eps;
    rx = 1'b0; wait_ticks(16);
    if (scramble) begin wls = ~wls; pen = ~pen; eps = ~eps; end
    for (int i = 0; i < nbits; i++) begin rx = d[i]; wait_ticks(16); end
    if (use_par) begin rx = pbit; wait_ticks(16); end
    rx = stop_b; wait_ticks(16);
    if (scramble) begin wls = s_wls; pen = s_pen; eps = s_eps; end
    rx = 1'b1;
  endtask

  initial begin
    int w0, o0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl_outputs", {rx_wr, perr, ferr, brk, ovr, busy}, 0);
    check("reset_data", rx_data, 0);
    rst_n = 1'b1;
    wait_ticks(20);

    // 8N1 0xA5
    wls = 2'd3; pen = 0;
    expect_wr(8'hA5, 0, 0, 0);
    send_char(8, 8'hA5, 0, 0, 1, 0);
    wait_ticks(4);
    check("a5_write_count", wr_cnt, 1);
    check("a5_busy_low", busy, 0);

    // 7E1 0x35: four ones, even parity bit 0 is correct
    wls = 2'd2; pen = 1; eps = 1;
    expect_wr(8'h35, 0, 0, 0);
    send_char(7, 8'h35, 1, 0, 1, 0);
    expect_wr(8'h35, 1, 0, 0);
    send_char(7, 8'h35, 1, 1, 1, 0);

    // 5O1 0x13: three ones, odd parity bit 0 is correct
    wls = 2'd0; pen = 1; eps = 0;
    expect_wr(8'h13, 0, 0, 0);
    send_char(5, 8'h13, 1, 0, 1, 0);

    // stick parity with eps=0: parity bit must be 1
    wls = 2'd3; pen = 1; eps = 0; stick = 1;
    expect_wr(8'h0F, 0, 0, 0);
    send_char(8, 8'h0F, 1, 1, 1, 0);
    expect_wr(8'h0F, 1, 0, 0);
    send_char(8, 8'h0F, 1, 0, 1, 0);
    stick = 0;

    // config changes mid-frame must not affect the current character; back-to-back frames
    wls = 2'd3; pen = 0; eps = 0;
    expect_wr(8'h96, 0, 0, 0);
    send_char(8, 8'h96, 0, 0, 1, 1);
    expect_wr(8'h12, 0, 0, 0);
    send_char(8, 8'h12, 0, 0, 1, 0);
    expect_wr(8'h34, 0, 0, 0);
    send_char(8, 8'h34, 0, 0, 1, 0);
    wait_ticks(8);
    check("b2b_write_count", wr_cnt, 9);

    // framing error then recovery
    expect_wr(8'h55, 0, 1, 0);
    send_char(8, 8'h55, 0, 0, 0, 0);
    wait_ticks(16);
    expect_wr(8'hAA, 0, 0, 0);
    send_char(8, 8'hAA, 0, 0, 1, 0);
    wait_ticks(8);

    // break: line low for 12 bit times
    w0 = wr_cnt;
    expect_wr(8'h00, 0, 1, 1);
    rx = 1'b0; wait_ticks(192);
    check("break_single_write", wr_cnt - w0, 1);
    check("break_busy_idle", busy, 0);
    rx = 1'b1; wait_ticks(32);
    check("break_no_second_write", wr_cnt - w0, 1);
    expect_wr(8'hC3, 0, 0, 0);
    send_char(8, 8'hC3, 0, 0, 1, 0);
    wait_ticks(8);

    // quarter-bit glitch is a false start
    w0 = wr_cnt;
    rx = 1'b0; wait_ticks(2);
    check("glitch_busy_rises", busy, 1);
    wait_ticks(2);
    rx = 1'b1; wait_ticks(8);
    check("glitch_busy_falls", busy, 0);
    wait_ticks(180);
    check("glitch_no_write", wr_cnt - w0, 0);

    // overrun then a normal character
    w0 = wr_cnt; o0 = ovr_cnt;
    full = 1'b1;
    expect_ovr();
    send_char(8, 8'h5A, 0, 0, 1, 0);
    full = 1'b0;
    check("overrun_count", ovr_cnt - o0, 1);
    check("overrun_no_write", wr_cnt - w0, 0);
    expect_wr(8'h3C, 0, 0, 0);
    send_char(8, 8'h3C, 0, 0, 1, 0);
    wait_ticks(8);
    check("after_overrun_write", wr_cnt - w0, 1);

    // reset in the middle of a frame discards it
    w0 = wr_cnt; o0 = ovr_cnt;
    rx = 1'b0; wait_ticks(16);
    rx = 1'b1; wait_ticks(16);
    rx = 1'b0; wait_ticks(16);
    rx = 1'b1;
    rst_n = 1'b0;
    wait_ticks(2);
    check("midreset_busy", busy, 0);
    rst_n = 1'b1;
    wait_ticks(200);
    check("midreset_no_output", (wr_cnt - w0) + (ovr_cnt - o0), 0);
    check("midreset_idle", busy, 0);

`ifdef UART_RX_TIMEOUT_EN
    wls = 2'd3; pen = 0;
    fifo_empty = 1'b0;
    to_n = -1;
    expect_wr(8'hE7, 0, 0, 0);
    fork
      send_char(8, 8'hE7, 0, 0, 1, 0);
      begin
        for (int i = 0; i < 20000 && !rx_wr; i++) @(negedge clk);
        @(posedge clk);
        to_n = 0;
        for (int i = 0; i < 4000; i++) begin
          @(posedge clk);
          if (tick) to_n++;
          #1;
          if (timeout) break;
        end
      end
    join
    check("timeout_rise_tick", to_n, 640);
    check("timeout_high", timeout, 1);
    fifo_rd = 1'b1;
    @(posedge clk);
    #1;
    fifo_rd = 1'b0;
    check("timeout_clear_on_rd", timeout, 0);
    fifo_empty = 1'b1;
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
